secuenciador_filtro: RTL and testbench
======================================

# secuenciador_filtro

Sequential controller for the other end of the arithmetic-unit interface: it drives the three operand buses into the combinational multiply-add unit, captures its result, and chains three passes to evaluate one first-order IIR sample, y[n] = a0·x[n] + a1·x[n-1] + b1·y[n-1]. It sits between the sample source (ADC side) and the output register feeding the DAC side. It also owns the filter history registers and a start/done handshake.

## Interface
- N, 16, word width of samples, coefficients and operand buses; matches the global `N`.
- F, 8, fractional bits of the signed fixed-point format (Q(N-F).F).
- clk  input  1  system clock, all state changes on rising edge.
- reset_n  input  1  reset; one clock; reset is synchronous and active-low.
- inicio  input  1  start request; sampled only in state REPOSO.
- x_in  input  N  new input sample; captured on the edge that accepts inicio.
- coef_a0, coef_a1, coef_b1  input  N each  signed Q coefficients; must be stable while ocupado=1.
- dato1, dato2, dato3  output  N each  operands to the multiply-add unit.
- resultado  input  N  multiply-add result, combinational from dato1..3 in the same cycle.
- y_out  output  N  last completed output sample, registered.
- listo  output  1  one-cycle pulse: y_out was updated on the previous edge.
- ocupado  output  1  high while a computation is in progress.

## Operation
- Unit contract: resultado = trunc(dato1·dato2 + dato3), signed, dato3 aligned to the product's binary point, truncated back to Q(N-F).F; no saturation, overflow wraps.
- FSM states: REPOSO, T0, T1, T2, FIN.
- REPOSO: dato1..3 = 0; ocupado=0. inicio=1 → latch x_in into xr, go T0.
- T0: dato1=coef_a0, dato2=xr, dato3=0; acc ← resultado; go T1.
- T1: dato1=coef_a1, dato2=x1, dato3=acc; acc ← resultado; go T2.
- T2: dato1=coef_b1, dato2=y1, dato3=acc; y_out ← resultado, y1 ← resultado, x1 ← xr; go FIN.
- FIN: listo=1, operands 0; go REPOSO unconditionally.
- Operand buses are a combinational mux of state and registers; resultado is sampled only at the end of T0/T1/T2.
- inicio asserted in T0..FIN is ignored (not queued); holding inicio high restarts in the cycle after FIN.
- History x1, y1 persist between samples; cleared only by reset.

## Timing
- Reset (reset_n=0 at an edge): state REPOSO; y_out, acc, xr, x1, y1 = 0; listo=0, ocupado=0, dato1..3=0.
- Reset mid-operation aborts: no listo, y_out and history cleared, x1/y1 not updated from the aborted sample.
- Inicio high in cycle 0 → T0 in cycle 1, T1 in 2, T2 in 3, y_out valid and listo=1 in cycle 4.
- ocupado=1 in cycles 1–3 (T0..T2), 0 in FIN and REPOSO.
- Throughput: one sample per 5 cycles with inicio held high.
- listo high exactly one cycle per completed sample.

## Test plan
- Reset: hold reset_n=0 two cycles with inicio=1 → y_out=0x0000, listo=0, ocupado=0, operands 0; release → no computation until inicio sampled in REPOSO.
- Single sample: a0=a1=0x0080, b1=0, x_in=0x0200, inicio pulse cycle 0 → listo cycle 4, y_out=0x0100; ocupado high cycles 1–3.
- History: follow with x_in=0x0400 → y_out=0x0300 (0.5·4 + 0.5·2).
- Feedback: a0=0x0100, a1=0, b1=0x0040, samples 0x0400 then 0x0000 → y_out 0x0400 then 0x0100.
- Ignored start: pulse inicio in cycle 2 of a computation → exactly one listo, result unchanged, x_in at cycle 2 not captured.
- Abort: reset_n=0 in cycle 2 → no listo; next sample with a0=a1=0x0080, b1=0, x=0x0200 gives 0x0100 (history cleared).

Source files
------------

// File: rtl/secuenciador_filtro.sv
// Purpose: sequences three multiply-add passes to evaluate one first-order IIR sample y = a0*x + a1*x1 + b1*y1.
// Latency: inicio sampled in REPOSO -> y_out updated and listo pulsed 4 cycles later; one sample per 5 cycles.
// Backpressure: none; inicio is accepted only in REPOSO, requests arriving while ocupado=1 are dropped, not queued.
module secuenciador_filtro #(
    parameter int N = 16,
    parameter int F = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inicio,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] coef_a0,
    input  logic [N-1:0] coef_a1,
    input  logic [N-1:0] coef_b1,
    output logic [N-1:0] dato1,
    output logic [N-1:0] dato2,
    output logic [N-1:0] dato3,
    input  logic [N-1:0] resultado,
    output logic [N-1:0] y_out,
    output logic         listo,
    output logic         ocupado
);

    typedef enum logic [2:0] {
        REPOSO = 3'd0,
        T0     = 3'd1,
        T1     = 3'd2,
        T2     = 3'd3,
        FIN    = 3'd4
    } estado_t;

    estado_t      estado;
    logic [N-1:0] xr;    // sample being processed
    logic [N-1:0] acc;   // partial sum between passes
    logic [N-1:0] x1;    // previous input sample
    logic [N-1:0] y1;    // previous output sample

    // A Q format with no integer bits cannot carry the sign; such a build has nothing to elaborate here.
    if (F >= N) begin : g_formato_q_invalido
    end

    // Sequencer: state, history and handshake outputs all change together on the rising edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado  <= REPOSO;
            xr      <= '0;
            acc     <= '0;
            x1      <= '0;
            y1      <= '0;
            y_out   <= '0;
            listo   <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        xr      <= x_in;
                        ocupado <= 1'b1;
                        estado  <= T0;
                    end
                end
                T0: begin
                    acc    <= resultado;
                    estado <= T1;
                end
                T1: begin
                    acc    <= resultado;
                    estado <= T2;
                end
                T2: begin
                    // History advances only when a sample fully completes.
                    y_out   <= resultado;
                    y1      <= resultado;
                    x1      <= xr;
                    listo   <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= FIN;
                end
                FIN: begin
                    estado <= REPOSO;
                end
                default: begin
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end
            endcase
        end
    end

    // Operand mux towards the multiply-add unit; buses idle at zero outside the three passes.
    always_comb begin
        dato1 = '0;
        dato2 = '0;
        dato3 = '0;
        case (estado)
            T0: begin
                dato1 = coef_a0;
                dato2 = xr;
            end
            T1: begin
                dato1 = coef_a1;
                dato2 = x1;
                dato3 = acc;
            end
            T2: begin
                dato1 = coef_b1;
                dato2 = y1;
                dato3 = acc;
            end
            default: begin
                dato1 = '0;
                dato2 = '0;
                dato3 = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Purpose: self-checking bench for secuenciador_filtro with a behavioural multiply-add unit on the operand buses.
// Latency: expected samples are queued at issue time and matched when listo is seen.
// Backpressure: not applicable; the bench drives inicio and watches listo/ocupado.
module tb_secuenciador_filtro;

    localparam int N = 16;
    localparam int F = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         inicio;
    logic [N-1:0] x_in;
    logic [N-1:0] coef_a0, coef_a1, coef_b1;
    logic [N-1:0] dato1, dato2, dato3;
    logic [N-1:0] resultado;
    logic [N-1:0] y_out;
    logic         listo;
    logic         ocupado;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] cola[$];
    logic listo_prev = 1'b0;

    secuenciador_filtro #(.N(N), .F(F)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .inicio    (inicio),
        .x_in      (x_in),
        .coef_a0   (coef_a0),
        .coef_a1   (coef_a1),
        .coef_b1   (coef_b1),
        .dato1     (dato1),
        .dato2     (dato2),
        .dato3     (dato3),
        .resultado (resultado),
        .y_out     (y_out),
        .listo     (listo),
        .ocupado   (ocupado)
    );

    always #5 clk = ~clk;

    // Multiply-add unit: trunc(d1*d2 + d3), d3 aligned to the product binary point, wrapping.
    function automatic logic [N-1:0] mac(input logic [N-1:0] d1, input logic [N-1:0] d2,
                                         input logic [N-1:0] d3);
        logic signed [2*N-1:0] p;
        logic signed [2*N-1:0] s;
        p = $signed(d1) * $signed(d2);
        s = p + ($signed({{N{d3[N-1]}}, d3}) <<< F);
        return s[F+N-1:F];
    endfunction

    assign resultado = mac(dato1, dato2, dato3);

    task automatic chk(input string nombre, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", nombre, act, exp, $time);
        end
    endtask

    // Monitor: every listo pulse must match the oldest queued expectation and last one cycle.
    always @(negedge clk) begin
        if (listo === 1'b1) begin
            checks++;
            if (cola.size() == 0) begin
                errors++;
                $display("FAIL listo_inesperado: got listo=1 with y_out=0x%04h expected no completion at %0t",
                         y_out, $time);
            end else begin
                logic [N-1:0] esperado;
                esperado = cola.pop_front();
                if (y_out !== esperado) begin
                    errors++;
                    $display("FAIL y_out: got 0x%04h expected 0x%04h at %0t", y_out, esperado, $time);
                end
            end
            checks++;
            if (listo_prev !== 1'b0) begin
                errors++;
                $display("FAIL listo_pulso: got listo high two cycles expected one at %0t", $time);
            end
        end
        listo_prev = listo;
    end

    // One sample: inicio in cycle 0, ocupado in cycles 1-3, listo in cycle 4.
    task automatic muestra(input logic [N-1:0] x, input logic [N-1:0] esperado);
        @(posedge clk); #1;
        inicio = 1'b1;
        x_in   = x;
        cola.push_back(esperado);
        @(posedge clk); #1;
        inicio = 1'b0;
        x_in   = 16'hDEAD;
        @(negedge clk);
        chk("ocupado_c1", {15'd0, ocupado}, 16'd1);
        chk("dato1_t0", dato1, coef_a0);
        chk("dato2_t0", dato2, x);
        @(negedge clk);
        chk("ocupado_c2", {15'd0, ocupado}, 16'd1);
        @(negedge clk);
        chk("ocupado_c3", {15'd0, ocupado}, 16'd1);
        @(negedge clk);
        chk("ocupado_c4", {15'd0, ocupado}, 16'd0);
        chk("listo_c4", {15'd0, listo}, 16'd1);
        chk("dato1_fin", dato1, 16'd0);
    endtask

    task automatic pulso_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        inicio  = 1'b1;
        x_in    = 16'h1234;
        coef_a0 = 16'h0080;
        coef_a1 = 16'h0080;
        coef_b1 = 16'h0000;

        // Reset held two cycles with inicio high.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_y_out", y_out, 16'h0000);
        chk("rst_listo", {15'd0, listo}, 16'd0);
        chk("rst_ocupado", {15'd0, ocupado}, 16'd0);
        chk("rst_dato1", dato1, 16'd0);
        chk("rst_dato2", dato2, 16'd0);
        chk("rst_dato3", dato3, 16'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        inicio  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ocupado", {15'd0, ocupado}, 16'd0);
        end

        // Single sample and history.
        muestra(16'h0200, 16'h0100);
        muestra(16'h0400, 16'h0300);

        // Feedback from clean history.
        pulso_reset();
        coef_a0 = 16'h0100;
        coef_a1 = 16'h0000;
        coef_b1 = 16'h0040;
        muestra(16'h0400, 16'h0400);
        muestra(16'h0000, 16'h0100);

        // Start request during a computation is dropped; x_in at that time is not captured.
        coef_a0 = 16'h0080;
        coef_a1 = 16'h0080;
        coef_b1 = 16'h0000;
        @(posedge clk); #1;
        inicio = 1'b1;
        x_in   = 16'h0200;
        cola.push_back(16'h0100);
        @(posedge clk); #1;
        inicio = 1'b0;
        @(posedge clk); #1;
        inicio = 1'b1;
        x_in   = 16'h7FFF;
        @(posedge clk); #1;
        inicio = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ign_listo_c4", {15'd0, listo}, 16'd1);
        @(negedge clk);
        chk("ign_ocupado_c5", {15'd0, ocupado}, 16'd0);
        @(negedge clk);
        chk("ign_ocupado_c6", {15'd0, ocupado}, 16'd0);
        // x1 must hold 0x0200, not 0x7FFF.
        muestra(16'h0200, 16'h0200);

        // Abort by reset in cycle 2.
        @(posedge clk); #1;
        inicio = 1'b1;
        x_in   = 16'h0600;
        @(posedge clk); #1;
        inicio = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_y_out", y_out, 16'h0000);
        chk("abort_ocupado", {15'd0, ocupado}, 16'd0);
        @(negedge clk);
        chk("abort_listo", {15'd0, listo}, 16'd0);
        muestra(16'h0200, 16'h0100);

        // Signed cases: negative coefficient and truncation toward minus infinity.
        coef_a0 = 16'hFF80;
        coef_a1 = 16'h0000;
        coef_b1 = 16'h0000;
        muestra(16'h0300, 16'hFE80);
        coef_a0 = 16'h0001;
        muestra(16'hFF01, 16'hFFFF);

        repeat (4) @(negedge clk);
        chk("cola_vacia", 16'(cola.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
